// File: rtl/nn_pkg.sv
// Shared definitions for the perceptron-network host loader: phase codes,
// frame geometry and the loader FSM encoding.
package nn_pkg;

  localparam int DATA_W    = 8;
  localparam int N_PARAM   = 24;
  localparam int N_INPUT   = 4;
  localparam int N_OUT     = 4;
  localparam int FRAME_LEN = N_PARAM + N_INPUT;
  localparam int CNT_W     = 5;

  localparam logic [1:0] PH_HOLD   = 2'd0;
  localparam logic [1:0] PH_PARAM  = 2'd1;
  localparam logic [1:0] PH_INPUT  = 2'd2;
  localparam logic [1:0] PH_OUTPUT = 2'd3;

  typedef enum logic [3:0] {
    ST_FILL   = 4'd0,
    ST_ENT_P  = 4'd1,
    ST_LOAD_P = 4'd2,
    ST_ENT_I  = 4'd3,
    ST_LOAD_I = 4'd4,
    ST_ENT_O  = 4'd5,
    ST_READ   = 4'd6,
    ST_EXIT   = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/nn_byte_buffer.sv
// Frame buffer: FRAME_LEN x DATA_W register file, one write port and one
// combinational read port; addresses past the frame read back as zero.
module nn_byte_buffer
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FRAME_LEN);

  logic [DATA_W-1:0] mem_r [FRAME_LEN];

  // Storage array, cleared on reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && (wr_addr < DEPTH)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < DEPTH) ? mem_r[rd_addr] : {DATA_W{1'b0}};

endmodule

// File: rtl/nn_stream_loader.sv
// Host-side driver for the 4-neuron perceptron network: buffers a 28-byte frame,
// replays it through the phase-step interface and returns the 4 neuron outputs.
module nn_stream_loader
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_W-1:0]       net_data,
  output logic                    net_change,
  output logic [1:0]              net_sel,
  input  logic [DATA_W-1:0]       net_out,
  output logic [N_OUT*DATA_W-1:0] r_data,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [1:0]              phase
);

  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] END_P    = CNT_W'(N_PARAM);
  localparam logic [CNT_W-1:0] END_I    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(N_OUT);

  state_t                  state_r;
  logic [CNT_W-1:0]        wr_cnt_r;
  logic [CNT_W-1:0]        rd_cnt_r;
  logic                    s_ready_r;
  logic [DATA_W-1:0]       net_data_r;
  logic                    net_change_r;
  logic [1:0]              net_sel_r;
  logic [N_OUT*DATA_W-1:0] r_data_r;
  logic                    r_valid_r;
  logic [1:0]              phase_r;
  logic                    wr_en_s;
  logic [DATA_W-1:0]       rd_data_s;
  logic [1:0]              slot_s;

  assign wr_en_s = (state_r == ST_FILL) && s_valid && s_ready_r;
  // In READ, count k captures the output selected one cycle earlier (slot k-1).
  assign slot_s  = rd_cnt_r[1:0] - 2'd1;

  nn_byte_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_cnt_r),
    .wr_data (s_data),
    .rd_addr (rd_cnt_r),
    .rd_data (rd_data_s)
  );

  // Loader FSM with all host and network outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FILL;
      wr_cnt_r     <= {CNT_W{1'b0}};
      rd_cnt_r     <= {CNT_W{1'b0}};
      s_ready_r    <= 1'b1;
      net_data_r   <= {DATA_W{1'b0}};
      net_change_r <= 1'b0;
      net_sel_r    <= 2'd0;
      r_data_r     <= {(N_OUT*DATA_W){1'b0}};
      r_valid_r    <= 1'b0;
      phase_r      <= PH_HOLD;
    end else begin
      net_change_r <= 1'b0;
      if (net_change_r) begin
        phase_r <= phase_r + 2'd1;
      end
      case (state_r)
        ST_FILL: begin
          if (wr_en_s) begin
            if (wr_cnt_r == LAST_WR) begin
              wr_cnt_r     <= {CNT_W{1'b0}};
              s_ready_r    <= 1'b0;
              net_change_r <= 1'b1;
              rd_cnt_r     <= {CNT_W{1'b0}};
              state_r      <= ST_ENT_P;
            end else begin
              wr_cnt_r <= wr_cnt_r + 5'd1;
            end
          end
        end
        ST_ENT_P, ST_ENT_I: begin
          net_data_r <= rd_data_s;
          rd_cnt_r   <= rd_cnt_r + 5'd1;
          state_r    <= (state_r == ST_ENT_P) ? ST_LOAD_P : ST_LOAD_I;
        end
        ST_LOAD_P, ST_LOAD_I: begin
          if (rd_cnt_r == ((state_r == ST_LOAD_P) ? END_P : END_I)) begin
            net_data_r   <= {DATA_W{1'b0}};
            net_change_r <= 1'b1;
            state_r      <= (state_r == ST_LOAD_P) ? ST_ENT_I : ST_ENT_O;
          end else begin
            net_data_r <= rd_data_s;
            rd_cnt_r   <= rd_cnt_r + 5'd1;
          end
        end
        ST_ENT_O: begin
          // Selector 0 is already presented here, so READ starts at selector 1.
          net_sel_r <= 2'd1;
          rd_cnt_r  <= 5'd1;
          state_r   <= ST_READ;
        end
        ST_READ: begin
          r_data_r[{slot_s, 3'b000} +: DATA_W] <= net_out;
          if (rd_cnt_r == LAST_RD) begin
            net_sel_r    <= 2'd0;
            net_change_r <= 1'b1;
            rd_cnt_r     <= {CNT_W{1'b0}};
            state_r      <= ST_EXIT;
          end else begin
            net_sel_r <= (rd_cnt_r >= 5'd3) ? 2'd3 : (rd_cnt_r[1:0] + 2'd1);
            rd_cnt_r  <= rd_cnt_r + 5'd1;
          end
        end
        ST_EXIT: begin
          r_valid_r <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (r_ready) begin
            r_valid_r <= 1'b0;
            r_data_r  <= {(N_OUT*DATA_W){1'b0}};
            s_ready_r <= 1'b1;
            state_r   <= ST_FILL;
          end
        end
        default: begin
          state_r   <= ST_FILL;
          s_ready_r <= 1'b1;
          wr_cnt_r  <= {CNT_W{1'b0}};
          rd_cnt_r  <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign s_ready    = s_ready_r;
  assign net_data   = net_data_r;
  assign net_change = net_change_r;
  assign net_sel    = net_sel_r;
  assign r_data     = r_data_r;
  assign r_valid    = r_valid_r;
  assign phase      = phase_r;

endmodule

// File: tb/tb_nn_stream_loader.sv
// Directed bench for nn_stream_loader with a registered network model
// (net_out follows net_sel one cycle later, ORed onto a per-frame base).
module tb_nn_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  net_data;
  logic        net_change;
  logic [1:0]  net_sel;
  logic [7:0]  net_out;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  out_base = 8'hA0;

  nn_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .net_data   (net_data),
    .net_change (net_change),
    .net_sel    (net_sel),
    .net_out    (net_out),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Network output register: one cycle of settle after the selector changes.
  always @(posedge clk or posedge reset) begin
    if (reset) net_out <= 8'h00;
    else       net_out <= out_base | {6'b000000, net_sel};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  int         pulse_q[$];
  logic [7:0] data_q[$];
  int         rv_cyc = -1;
  int         nc_double = 0;
  bit         prev_nc = 1'b0;
  int         acc_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (net_change) pulse_q.push_back(cyc);
      if (net_change && prev_nc) nc_double++;
      if (net_data != 8'h00) data_q.push_back(net_data);
      if (r_valid && rv_cyc < 0) rv_cyc = cyc;
    end
    prev_nc = net_change;
  end

  task automatic clear_mon();
    pulse_q.delete();
    data_q.delete();
    rv_cyc = -1;
    nc_double = 0;
  endtask

  task automatic send_frame(input logic [7:0] first, input bit gaps);
    for (int i = 0; i < 28; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_data  = first + 8'(i);
      s_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc - 1;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] first, input logic [31:0] exp_r);
    int n = 0;
    int exp_p[4] = '{1, 26, 31, 36};
    while (!r_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_rvalid"}, {31'd0, r_valid}, 32'd1);
    chk({tag, "_npulse"}, pulse_q.size(), 32'd4);
    if (pulse_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk({tag, "_pulse"}, pulse_q[i] - acc_cyc, exp_p[i]);
    end
    chk({tag, "_nbytes"}, data_q.size(), 32'd28);
    for (int i = 0; i < 28 && i < data_q.size(); i++) begin
      chk({tag, "_byte"}, {24'd0, data_q[i]}, {24'd0, first + 8'(i)});
    end
    chk({tag, "_latency"}, rv_cyc - acc_cyc, 32'd37);
    chk({tag, "_rdata"}, r_data, exp_r);
    chk({tag, "_nc_double"}, nc_double, 32'd0);
    chk({tag, "_sready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_phase"}, {30'd0, phase}, 32'd0);
  endtask

  task automatic ack(input string tag);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    s_valid = 1'b0;
    chk({tag, "_ack_sready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_ack_rvalid"}, {31'd0, r_valid}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_netdata"}, {24'd0, net_data}, 32'd0);
    chk({tag, "_netchg"}, {31'd0, net_change}, 32'd0);
    chk({tag, "_netsel"}, {30'd0, net_sel}, 32'd0);
    chk({tag, "_rdata"}, r_data, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, r_valid}, 32'd0);
    chk({tag, "_phase"}, {30'd0, phase}, 32'd0);
  endtask

  initial begin
    // Test 1: reset asserted mid-clock takes effect immediately.
    #3 reset = 1'b1;
    #1 check_reset_vals("t1_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Test 2: back-to-back frame 0x01..0x1C.
    clear_mon();
    out_base = 8'hA0;
    send_frame(8'h01, 1'b0);
    check_frame("t2", 8'h01, 32'hA3A2A1A0);

    // Test 3: backpressure, with host bytes offered that must be ignored.
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (10) @(posedge clk);
    #1;
    chk("t3_rvalid_hold", {31'd0, r_valid}, 32'd1);
    chk("t3_rdata_hold", r_data, 32'hA3A2A1A0);
    chk("t3_sready_low", {31'd0, s_ready}, 32'd0);
    ack("t3");

    // Test 4: same frame with random valid gaps.
    clear_mon();
    send_frame(8'h01, 1'b1);
    check_frame("t4", 8'h01, 32'hA3A2A1A0);
    ack("t4");

    // Test 5: reset during LOAD_P after 10 bytes shifted.
    clear_mon();
    send_frame(8'h01, 1'b0);
    begin
      int n = 0;
      while (data_q.size() < 10 && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_ten_bytes", data_q.size(), 32'd10);
    chk("t5_phase_param", {30'd0, phase}, 32'd1);
    reset = 1'b1;
    #1 check_reset_vals("t5_abort");
    @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    out_base = 8'h30;
    send_frame(8'h61, 1'b0);
    check_frame("t5_new", 8'h61, 32'h33323130);
    ack("t5");

    // Test 6: two frames with distinct data and network outputs.
    clear_mon();
    out_base = 8'h50;
    send_frame(8'h40, 1'b0);
    check_frame("t6a", 8'h40, 32'h53525150);
    ack("t6a");
    clear_mon();
    out_base = 8'hC0;
    send_frame(8'h81, 1'b0);
    check_frame("t6b", 8'h81, 32'hC3C2C1C0);
    ack("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
